small_fifo_fwft: RTL and testbench

//   Parametrised successor to the small register FIFO: adds a selectable

---
 rtl/small_fifo_fwft.sv | 175 +++++++++++++++++
 tb/tb_small_fifo_fwft.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/small_fifo_fwft.sv
// small_fifo_fwft: register-array FIFO with selectable standard or
// first-word-fall-through read mode, an occupancy count, threshold flags and
// sticky overflow/underflow error flags. Capacity is 2**MAX_DEPTH_BITS words.
// In FWFT mode the word shown on dout counts towards that capacity.
module small_fifo_fwft #(
    parameter int WIDTH                = 72,
    parameter int MAX_DEPTH_BITS       = 3,
    parameter int FWFT                 = 0,
    parameter int NEARLY_FULL          = 2**MAX_DEPTH_BITS - 1,
    parameter int PROG_FULL_THRESHOLD  = 2**MAX_DEPTH_BITS - 1,
    parameter int PROG_EMPTY_THRESHOLD = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        din,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    nearly_full,
    output logic                    prog_full,
    output logic                    empty,
    output logic                    prog_empty,
    output logic [MAX_DEPTH_BITS:0] count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int DEPTH = 2**MAX_DEPTH_BITS;
    localparam int PTR_W = MAX_DEPTH_BITS;
    localparam int CNT_W = MAX_DEPTH_BITS + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_NF   = CNT_W'(NEARLY_FULL);
    localparam logic [CNT_W-1:0] CNT_PF   = CNT_W'(PROG_FULL_THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_PE   = CNT_W'(PROG_EMPTY_THRESHOLD);

    // Storage is deliberately not reset: pointers and count define validity.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             full_q, nearly_full_q, prog_full_q, empty_q, prog_empty_q;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc_s, wr_acc_s;

    // Accept/reject decisions; a read frees a slot for a same-cycle write.
    always_comb begin
        rd_acc_s = rd_en & ~empty_q;
        wr_acc_s = wr_en & (~full_q | rd_acc_s);
    end

    // Pointer, occupancy and sticky error next-state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A new error event wins over a clear in the same cycle.
        if (wr_en && !wr_acc_s) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (rd_en && empty_q) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Output data next-state: fall-through shows the head word, standard mode
    // loads the head only on an accepted read.
    always_comb begin
        dout_d = dout_q;
        if (FWFT != 0) begin
            if (count_d != CNT_ZERO) begin
                // Writing into an empty FIFO: the new word becomes the head now.
                if (wr_acc_s && (wr_ptr_q == rd_ptr_d)) begin
                    dout_d = din;
                end else begin
                    dout_d = mem_q[rd_ptr_d];
                end
            end else begin
                dout_d = dout_q;
            end
        end else begin
            if (rd_acc_s) begin
                dout_d = mem_q[rd_ptr_q];
            end else begin
                dout_d = dout_q;
            end
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Control state, output data and flags decoded from the next count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= PTR_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            count_q       <= CNT_ZERO;
            dout_q        <= {WIDTH{1'b0}};
            full_q        <= 1'b0;
            nearly_full_q <= 1'b0;
            prog_full_q   <= 1'b0;
            empty_q       <= 1'b1;
            prog_empty_q  <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            dout_q        <= dout_d;
            full_q        <= (count_d == CNT_MAX);
            nearly_full_q <= (count_d >= CNT_NF);
            prog_full_q   <= (count_d >= CNT_PF);
            empty_q       <= (count_d == CNT_ZERO);
            prog_empty_q  <= (count_d <= CNT_PE);
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    assign dout        = dout_q;
    assign full        = full_q;
    assign nearly_full = nearly_full_q;
    assign prog_full   = prog_full_q;
    assign empty       = empty_q;
    assign prog_empty  = prog_empty_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_small_fifo_fwft.sv
// tb_small_fifo_fwft: drives a standard-mode and a fall-through instance with
// identical stimulus and compares both against a queue-based reference model.
module tb_small_fifo_fwft;

    localparam int W     = 16;
    localparam int DB    = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset;
    logic [W-1:0]  din;
    logic          wr_en, rd_en, err_clr;

    logic [W-1:0]  dout0, dout1;
    logic          full0, nfull0, pfull0, empty0, pempty0, ovf0, udf0;
    logic          full1, nfull1, pfull1, empty1, pempty1, ovf1, udf1;
    logic [DB:0]   count0, count1;

    small_fifo_fwft #(.WIDTH(W), .MAX_DEPTH_BITS(DB), .FWFT(0)) dut_std (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .err_clr(err_clr), .dout(dout0), .full(full0), .nearly_full(nfull0),
        .prog_full(pfull0), .empty(empty0), .prog_empty(pempty0),
        .count(count0), .overflow(ovf0), .underflow(udf0)
    );

    small_fifo_fwft #(.WIDTH(W), .MAX_DEPTH_BITS(DB), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .err_clr(err_clr), .dout(dout1), .full(full1), .nearly_full(nfull1),
        .prog_full(pfull1), .empty(empty1), .prog_empty(pempty1),
        .count(count1), .overflow(ovf1), .underflow(udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the FIFO contents as a queue, oldest word at index 0.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_dout0;
    logic         m_ovf, m_udf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = m_q.size();
        check_eq("count_std",   64'(count0), 64'(sz));
        check_eq("count_fwft",  64'(count1), 64'(sz));
        check_eq("empty_std",   64'(empty0), 64'(sz == 0));
        check_eq("empty_fwft",  64'(empty1), 64'(sz == 0));
        check_eq("full_std",    64'(full0),  64'(sz == DEPTH));
        check_eq("full_fwft",   64'(full1),  64'(sz == DEPTH));
        check_eq("nfull_std",   64'(nfull0), 64'(sz >= DEPTH - 1));
        check_eq("nfull_fwft",  64'(nfull1), 64'(sz >= DEPTH - 1));
        check_eq("pfull_std",   64'(pfull0), 64'(sz >= DEPTH - 1));
        check_eq("pfull_fwft",  64'(pfull1), 64'(sz >= DEPTH - 1));
        check_eq("pempty_std",  64'(pempty0), 64'(sz <= 1));
        check_eq("pempty_fwft", 64'(pempty1), 64'(sz <= 1));
        check_eq("ovf_std",     64'(ovf0), 64'(m_ovf));
        check_eq("ovf_fwft",    64'(ovf1), 64'(m_ovf));
        check_eq("udf_std",     64'(udf0), 64'(m_udf));
        check_eq("udf_fwft",    64'(udf1), 64'(m_udf));
        check_eq("dout_std",    64'(dout0), 64'(m_dout0));
        if (sz > 0) begin
            check_eq("dout_fwft", 64'(dout1), 64'(m_q[0]));
        end
    endtask

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic cycle(input logic wr, input logic rd, input logic clr, input logic [W-1:0] d);
        bit was_empty, was_full, racc, wacc;
        logic [W-1:0] popped;
        wr_en   = wr;
        rd_en   = rd;
        err_clr = clr;
        din     = d;
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == DEPTH);
        racc = rd && !was_empty;
        wacc = wr && (!was_full || racc);
        if (racc) begin
            popped  = m_q.pop_front();
            m_dout0 = popped;
        end
        if (wacc) m_q.push_back(d);
        if (wr && !wacc) m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
        if (rd && was_empty) m_udf = 1'b1;
        else if (clr)        m_udf = 1'b0;
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse asserted between clock edges.
    task automatic pulse_reset();
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        m_q.delete();
        m_dout0 = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        check_all();
        check_eq("rst_dout_fwft", 64'(dout1), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        reset = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        m_dout0 = '0; m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        check_eq("init_dout_fwft", 64'(dout1), 64'd0);
        reset = 1'b0;

        // Reset in the middle of a burst, then a fresh word survives.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, W'(16'h0100 + i));
        check_eq("pre_rst_count", 64'(count0), 64'd5);
        pulse_reset();
        cycle(1'b1, 1'b0, 1'b0, 16'h00A5);
        check_eq("a5_fwft_fall", 64'(dout1), 64'h00A5);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        check_eq("a5_std_read", 64'(dout0), 64'h00A5);

        // Fill to capacity, overflow, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0, W'(i));
            if (i == DEPTH - 2) check_eq("nfull_at7", 64'(nfull0), 64'd1);
        end
        check_eq("full_at8", 64'(full0), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 16'hDEAD);
        check_eq("ovf_9th", 64'(ovf0), 64'd1);
        check_eq("count_9th", 64'(count0), 64'd8);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 16'h0000);
            check_eq("drain_order", 64'(dout0), 64'(i));
        end
        check_eq("drained_empty", 64'(empty0), 64'd1);

        // Full FIFO with simultaneous read and write over three wraps.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, W'(16'h2000 + i));
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle(1'b1, 1'b1, 1'b0, W'(16'h3000 + i));
            check_eq("rw_full_count", 64'(count0), 64'd8);
        end
        check_eq("rw_full_no_ovf", 64'(ovf0), 64'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        check_eq("last_word", 64'(dout0), 64'(16'h3000 + 3 * DEPTH - 1));

        // Fall-through: write to empty shows immediately; streaming reads.
        cycle(1'b1, 1'b0, 1'b0, 16'h0011);
        check_eq("fwft_11", 64'(dout1), 64'h0011);
        check_eq("fwft_11_ne", 64'(empty1), 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, W'(16'h0012 + i));
        for (int i = 0; i < 4; i++) begin
            if (i < 4) check_eq("fwft_stream", 64'(dout1), 64'(16'h0011 + i));
            cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        end
        check_eq("fwft_stream_empty", 64'(empty1), 64'd1);

        // Underflow, clear, and set-beats-clear.
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        check_eq("udf_set", 64'(udf0), 64'd1);
        check_eq("udf_dout_hold", 64'(dout0), 64'h0014);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000);
        check_eq("udf_clr", 64'(udf0), 64'd0);
        cycle(1'b0, 1'b1, 1'b1, 16'h0000);
        check_eq("udf_priority", 64'(udf0), 64'd1);
        cycle(1'b1, 1'b1, 1'b1, 16'h0077);
        check_eq("empty_rw_write", 64'(count0), 64'd1);

        // Randomised traffic with shifting read/write bias.
        for (int i = 0; i < 10000; i++) begin
            int pw, pr;
            pw = 20 + 15 * ((i / 700) % 5);
            pr = 20 + 15 * ((i / 900) % 5);
            cycle($urandom_range(99) < pw, $urandom_range(99) < pr,
                  $urandom_range(99) < 3, W'($urandom));
            if (i == 5000) pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
